// File: rtl/bsg_dlatch_array_write_ctrl.sv
// Write sequencer for a D-latch array: setup/open/hold around a one-hot enable.
// Define BSG_DLATCH_WRITE_CTRL_HOLD_EXT_EN to stretch HOLD to hold_cycles_p.
module bsg_dlatch_array_write_ctrl #(
  parameter int els_p         = 8,
  parameter int width_p       = 32,
  parameter int addr_width_lp = $clog2(els_p),
  parameter int hold_cycles_p = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  output logic                     w_ready_o,
  output logic [width_p-1:0]       latch_data_o,
  output logic [els_p-1:0]         latch_en_o,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic                     r_conflict_o,
  output logic                     err_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD
  } state_e;

  localparam logic [addr_width_lp:0] els_lp =
    (addr_width_lp+1)'(els_p);

  state_e                   state_q, state_d;
  logic [addr_width_lp-1:0] addr_q, addr_d;
  logic [width_p-1:0]       data_q, data_d;
  logic [els_p-1:0]         en_q, en_d;
  logic                     err_q, err_d;
  logic                     in_range;

`ifdef BSG_DLATCH_WRITE_CTRL_HOLD_EXT_EN
  localparam int hold_w_lp = $clog2(hold_cycles_p + 1);
  logic [hold_w_lp-1:0] hold_q, hold_d;
`endif

  assign in_range = {1'b0, w_addr_i} < els_lp;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = '0;
    err_d   = err_q;
`ifdef BSG_DLATCH_WRITE_CTRL_HOLD_EXT_EN
    hold_d  = hold_q;
`endif
    unique case (1'b1)
      (state_q == IDLE): begin
        if (w_v_i) begin
          state_d = SETUP;
          addr_d  = w_addr_i;
          data_d  = w_data_i;
          if (!in_range) err_d = 1'b1;
        end
      end
      (state_q == SETUP): begin
        state_d = OPEN;
        // out-of-range addresses match no entry
        for (int i = 0; i < els_p; i++)
          en_d[i] = (addr_q == addr_width_lp'(i));
      end
      (state_q == OPEN): begin
        state_d = HOLD;
`ifdef BSG_DLATCH_WRITE_CTRL_HOLD_EXT_EN
        hold_d  = hold_w_lp'(hold_cycles_p);
`endif
      end
      (state_q == HOLD): begin
`ifdef BSG_DLATCH_WRITE_CTRL_HOLD_EXT_EN
        if (hold_q <= hold_w_lp'(1)) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q - hold_w_lp'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= '0;
      err_q   <= 1'b0;
`ifdef BSG_DLATCH_WRITE_CTRL_HOLD_EXT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      err_q   <= err_d;
`ifdef BSG_DLATCH_WRITE_CTRL_HOLD_EXT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign w_ready_o    = (state_q == IDLE);
  assign busy_o       = ~w_ready_o;
  assign latch_en_o   = en_q;
  assign latch_data_o = data_q;
  assign err_o        = err_q;
  assign r_conflict_o = busy_o & (r_addr_i == addr_q);

endmodule

// File: tb/tb_bsg_dlatch_array_write_ctrl.sv
// Directed vector bench for bsg_dlatch_array_write_ctrl.
// Covers main timing, conflicts, out-of-range, async reset, hold stretch.
module tb_bsg_dlatch_array_write_ctrl;

`ifdef BSG_DLATCH_WRITE_CTRL_HOLD_EXT_EN
  localparam int HC = 3;
`else
  localparam int HC = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut8: els 8, hold 1
  logic        v8, rc8, rdy8, err8, busy8;
  logic [2:0]  a8, ra8;
  logic [31:0] d8, dat8;
  logic [7:0]  en8;

  // dut6: els 6
  logic        v6, rc6, rdy6, err6, busy6;
  logic [2:0]  a6, ra6;
  logic [31:0] d6, dat6;
  logic [5:0]  en6;

  // duth: els 8, hold 3 when stretched
  logic        vh, rch, rdyh, errh, busyh;
  logic [2:0]  ah, rah;
  logic [31:0] dh, dath;
  logic [7:0]  enh;

  bsg_dlatch_array_write_ctrl #(
    .els_p(8), .width_p(32), .hold_cycles_p(1)
  ) dut8 (
    .clk_i(clk), .reset_n_i(rst_n),
    .w_v_i(v8), .w_addr_i(a8), .w_data_i(d8),
    .w_ready_o(rdy8), .latch_data_o(dat8),
    .latch_en_o(en8), .r_addr_i(ra8),
    .r_conflict_o(rc8), .err_o(err8), .busy_o(busy8)
  );

  bsg_dlatch_array_write_ctrl #(
    .els_p(6), .width_p(32), .hold_cycles_p(1)
  ) dut6 (
    .clk_i(clk), .reset_n_i(rst_n),
    .w_v_i(v6), .w_addr_i(a6), .w_data_i(d6),
    .w_ready_o(rdy6), .latch_data_o(dat6),
    .latch_en_o(en6), .r_addr_i(ra6),
    .r_conflict_o(rc6), .err_o(err6), .busy_o(busy6)
  );

  bsg_dlatch_array_write_ctrl #(
    .els_p(8), .width_p(32), .hold_cycles_p(3)
  ) duth (
    .clk_i(clk), .reset_n_i(rst_n),
    .w_v_i(vh), .w_addr_i(ah), .w_data_i(dh),
    .w_ready_o(rdyh), .latch_data_o(dath),
    .latch_en_o(enh), .r_addr_i(rah),
    .r_conflict_o(rch), .err_o(errh), .busy_o(busyh)
  );

  typedef struct {
    logic        v;
    logic [2:0]  a;
    logic [31:0] d;
    logic [2:0]  ra;
    logic        rdy;
    logic [7:0]  en;
    logic [31:0] dat;
    logic        cf;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input logic v, input logic [2:0] a, input logic [31:0] d,
    input logic [2:0] ra, input logic rdy, input logic [7:0] en,
    input logic [31:0] dat, input logic cf);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.ra = ra;
    r.rdy = rdy; r.en = en; r.dat = dat; r.cf = cf;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    v8 = 0; a8 = 0; d8 = 0; ra8 = 0;
    v6 = 0; a6 = 0; d6 = 0; ra6 = 0;
    vh = 0; ah = 0; dh = 0; rah = 0;

    // write 3, then back-to-back 0 / 7, then conflicts on 5
    tbl.push_back(mk(1, 3, 32'hDEADBEEF, 3, 1, 8'h00, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 3, 0, 8'h00, 32'hDEADBEEF, 1));
    tbl.push_back(mk(0, 0, 32'h0, 3, 0, 8'h08, 32'hDEADBEEF, 1));
    tbl.push_back(mk(0, 0, 32'h0, 3, 0, 8'h00, 32'hDEADBEEF, 1));
    tbl.push_back(mk(0, 0, 32'h0, 3, 1, 8'h00, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 0, 32'h11111111, 3, 1, 8'h00, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 7, 32'h77777777, 0, 0, 8'h00, 32'h11111111, 1));
    tbl.push_back(mk(1, 7, 32'h77777777, 7, 0, 8'h01, 32'h11111111, 0));
    tbl.push_back(mk(1, 7, 32'h77777777, 0, 0, 8'h00, 32'h11111111, 1));
    tbl.push_back(mk(1, 7, 32'h77777777, 7, 1, 8'h00, 32'h11111111, 0));
    tbl.push_back(mk(0, 0, 32'h0, 7, 0, 8'h00, 32'h77777777, 1));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 8'h80, 32'h77777777, 0));
    tbl.push_back(mk(0, 0, 32'h0, 7, 0, 8'h00, 32'h77777777, 1));
    tbl.push_back(mk(0, 0, 32'h0, 7, 1, 8'h00, 32'h77777777, 0));
    tbl.push_back(mk(1, 5, 32'hA5A5A5A5, 5, 1, 8'h00, 32'h77777777, 0));
    tbl.push_back(mk(0, 0, 32'h0, 5, 0, 8'h00, 32'hA5A5A5A5, 1));
    tbl.push_back(mk(0, 0, 32'h0, 4, 0, 8'h20, 32'hA5A5A5A5, 0));
    tbl.push_back(mk(0, 0, 32'h0, 5, 0, 8'h00, 32'hA5A5A5A5, 1));
    tbl.push_back(mk(0, 0, 32'h0, 5, 1, 8'h00, 32'hA5A5A5A5, 0));
    tbl.push_back(mk(0, 0, 32'h0, 4, 1, 8'h00, 32'hA5A5A5A5, 0));

    // reset state
    #12;
    chk("rst_rdy", 32'(rdy8), 1);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_en", 32'(en8), 0);
    chk("rst_dat", dat8, 0);
    chk("rst_cf", 32'(rc8), 0);
    chk("rst_err", 32'(err8), 0);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      v8 = tbl[i].v; a8 = tbl[i].a; d8 = tbl[i].d; ra8 = tbl[i].ra;
      #1;
      chk($sformatf("row%0d_rdy", i), 32'(rdy8), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_busy", i), 32'(busy8), 32'(!tbl[i].rdy));
      chk($sformatf("row%0d_en", i), 32'(en8), 32'(tbl[i].en));
      chk($sformatf("row%0d_dat", i), dat8, tbl[i].dat);
      chk($sformatf("row%0d_cf", i), 32'(rc8), 32'(tbl[i].cf));
      tick();
    end
    v8 = 0;

    // out-of-range write on els 6, then a valid write
    for (int c = 0; c <= 8; c++) begin
      v6 = (c == 0) || (c == 4);
      a6 = (c == 0) ? 3'd6 : 3'd2;
      d6 = (c == 0) ? 32'hAAAA5555 : 32'h12345678;
      ra6 = (c == 2) ? 3'd6 : 3'd0;
      #1;
      chk($sformatf("oor%0d_en", c), 32'(en6),
          (c == 6) ? 32'h04 : 32'h0);
      chk($sformatf("oor%0d_rdy", c), 32'(rdy6),
          (c == 0 || c == 4 || c == 8) ? 1 : 0);
      chk($sformatf("oor%0d_err", c), 32'(err6), (c == 0) ? 0 : 1);
      if (c == 1) chk("oor_dat", dat6, 32'hAAAA5555);
      if (c == 2) chk("oor_cf", 32'(rc6), 1);
      if (c == 5) chk("oor_dat2", dat6, 32'h12345678);
      tick();
    end
    v6 = 0;

    // hold length (stretched when the extension is compiled in)
    for (int c = 0; c <= HC + 3; c++) begin
      vh = (c == 0); ah = 3'd2; dh = 32'hCAFEF00D;
      #1;
      chk($sformatf("hold%0d_en", c), 32'(enh),
          (c == 2) ? 32'h04 : 32'h0);
      chk($sformatf("hold%0d_rdy", c), 32'(rdyh),
          (c == 0 || c >= 3 + HC) ? 1 : 0);
      chk($sformatf("hold%0d_dat", c), dath,
          (c == 0) ? 32'h0 : 32'hCAFEF00D);
      tick();
    end
    vh = 0;

    // async reset during OPEN
    v8 = 1; a8 = 3'd1; d8 = 32'h0F0F0F0F;
    #1 chk("ar_rdy0", 32'(rdy8), 1);
    tick();
    v8 = 0;
    tick();
    chk("ar_open_en", 32'(en8), 32'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en", 32'(en8), 0);
    chk("ar_rdy", 32'(rdy8), 1);
    chk("ar_busy", 32'(busy8), 0);
    chk("ar_dat", dat8, 0);
    chk("ar_err6", 32'(err6), 0);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_after_en", 32'(en8), 0);
    chk("ar_after_rdy", 32'(rdy8), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
